counter_sweep_ctrl: RTL and testbench
=====================================

Name: counter_sweep_ctrl

Overview:
Sequencer for the shared up/down counter (load/en/dir contract below). It runs the counter in a triangle sweep lo_lim→hi_lim→lo_lim for a programmed number of cycles, with a start/busy/done handshake and abort. It sits between the config/register side and the counter; c_in is the counter's c_out fed back.
Counter contract: at posedge clk, if cnt_load then c<=cnt_ld_val; else if cnt_en then c<=cnt_dir ? c+1 : c-1 (dir=1 is "+").

Parameters:
W, 8, counter/limit width
CYC_W, 8, width of cycle count n_cyc and cyc_cnt
DWELL, 4, hold cycles at each limit (used only with SWEEP_DWELL_EN, 1..255)

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-high
start  in  1  start request, sampled in IDLE only
abort  in  1  terminate sweep, sampled when busy
lo_lim  in  W  lower sweep limit
hi_lim  in  W  upper sweep limit
n_cyc  in  CYC_W  full triangle cycles to run
c_in  in  W  counter value feedback
cnt_load  out  1  counter load strobe
cnt_ld_val  out  W  counter load value
cnt_en  out  1  counter enable
cnt_dir  out  1  counter direction, 1 = up
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done: config error or abort
cyc_cnt  out  CYC_W  completed cycles

Behaviour:
- Reset (resetn=1, async): state IDLE; busy, done, err, cyc_cnt, shadow regs = 0; all cnt_* outputs 0.
- cnt_* outputs are Mealy, decoded from state and c_in, so they act on the same edge with no overshoot.
- States: IDLE, LOAD, UP, DOWN, DONE (plus DW_HI and DW_LO with the optional feature).
- IDLE: cnt_* = 0. On start=1, latch lo_lim, hi_lim, n_cyc into shadow regs and clear cyc_cnt. If lo_lim>=hi_lim or n_cyc==0, go to DONE with err=1; otherwise go to LOAD.
- LOAD (1 cycle): cnt_load=1, cnt_ld_val=lo_r. Next state UP.
- UP: cnt_en=1.
  - c_in!=hi_r: cnt_dir=1.
  - c_in==hi_r: cnt_dir=0, go to DOWN.
- DOWN: cnt_en=1.
  - c_in!=lo_r: cnt_dir=0.
  - c_in==lo_r: cyc_cnt+1. If the new value == n_cyc_r, cnt_en=0 and go to DONE (err=0). Otherwise cnt_dir=1 and go to UP.
- DONE (1 cycle): done=1, err held, cnt_* = 0, busy=1. Next state IDLE; busy falls the following cycle.
- abort=1 in LOAD/UP/DOWN/DW_*: that cycle cnt_en=0 and cnt_load=0, go to DONE with err=1. Counter value is frozen; cyc_cnt is kept.
- Abort has priority over a same-cycle limit turnaround or completion.
- start while busy: ignored. lo_lim/hi_lim/n_cyc changes while busy: ignored (shadowed).
- Latency: start sampled at edge k → LOAD during cycle k+1 → c_in=lo at k+2.
- Counter never leaves [lo_r, hi_r]; no wrap-around is ever commanded.
- cyc_cnt saturates at n_cyc_r; it has no wrap path.
- hi_r = lo_r+1 is legal: the sweep alternates lo, hi.

Optional Feature:
SWEEP_DWELL_EN
- Defined: reaching hi_r in UP goes to DW_HI, and reaching lo_r in DOWN (not final) goes to DW_LO. These states hold cnt_en=0 for DWELL cycles, then go to DOWN or UP respectively. An internal 8-bit dwell counter is used; abort is honoured during dwell.
- Undefined: turnaround is immediate as above; dwell logic and the DWELL parameter are unused.

Test Plan:
- Reset mid-sweep: resetn=1 while UP at c_in=4 → next sample all outputs 0, busy=0, state IDLE; start then works normally.
- Basic sweep, lo=2, hi=5, n_cyc=2, DWELL off → c_in=2,3,4,5,4,3,2,3,4,5,4,3,2. done one cycle after the final 2, err=0, cyc_cnt=2, c_in stays 2.
- Bad config: lo=5, hi=5 (or n_cyc=0) + start → DONE next cycle, done=1 and err=1, no cnt_load ever asserted.
- Abort: lo=0, hi=255, n_cyc=1, abort at c_in=0x40 in UP → counter frozen at 0x40 (or 0x41 if the edge already passed), done=1 and err=1, cyc_cnt=0.
- Handshake:
  - start held high, and re-pulsed during busy → only one sweep.
  - Changing hi_lim mid-sweep → no effect.
  - Back-to-back start in the cycle after IDLE is re-entered → second sweep starts.
- SWEEP_DWELL_EN, DWELL=3, lo=1, hi=3, n_cyc=1 → c_in=1,2,3,3,3,3,2,1; cnt_en=0 for exactly 3 cycles at 3, done after the final 1.

Source files
------------

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for the shared up/down counter (lo -> hi -> lo, n cycles).
// Optional hold at each turnaround point: define SWEEP_DWELL_EN (hold length = DWELL).
module counter_sweep_ctrl #(
    parameter int W     = 8,
    parameter int CYC_W = 8,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     lo_lim,
    input  logic [W-1:0]     hi_lim,
    input  logic [CYC_W-1:0] n_cyc,
    input  logic [W-1:0]     c_in,
    output logic             cnt_load,
    output logic [W-1:0]     cnt_ld_val,
    output logic             cnt_en,
    output logic             cnt_dir,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CYC_W-1:0] cyc_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_UP    = 3'd2,
        S_DOWN  = 3'd3,
        S_DONE  = 3'd4,
        S_DW_HI = 3'd5,
        S_DW_LO = 3'd6
    } state_t;

    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

    state_t             state_r;
    state_t             next_state_s;
    logic [W-1:0]       lo_r;
    logic [W-1:0]       hi_r;
    logic [CYC_W-1:0]   n_cyc_r;
    logic [CYC_W-1:0]   cyc_cnt_r;
    logic [CYC_W-1:0]   cyc_next_s;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic               latch_s;
    logic               err_set_s;
    logic               cyc_inc_s;
    logic               cnt_load_s;
    logic [W-1:0]       cnt_ld_val_s;
    logic               cnt_en_s;
    logic               cnt_dir_s;
`ifdef SWEEP_DWELL_EN
    localparam logic [7:0] DWELL_C = 8'(DWELL);
    logic [7:0]         dwell_r;
    logic               dwell_ld_s;
    logic               dwell_inc_s;
`endif

    assign cyc_next_s = cyc_cnt_r + CYC_ONE;

    // Next-state and Mealy counter-command decode; abort always wins over turnaround/completion.
    always_comb begin
        next_state_s = state_r;
        latch_s      = 1'b0;
        err_set_s    = 1'b0;
        cyc_inc_s    = 1'b0;
        cnt_load_s   = 1'b0;
        cnt_ld_val_s = {W{1'b0}};
        cnt_en_s     = 1'b0;
        cnt_dir_s    = 1'b0;
`ifdef SWEEP_DWELL_EN
        dwell_ld_s   = 1'b0;
        dwell_inc_s  = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    latch_s = 1'b1;
                    if ((lo_lim >= hi_lim) || (n_cyc == {CYC_W{1'b0}})) begin
                        err_set_s    = 1'b1;
                        next_state_s = S_DONE;
                    end else begin
                        next_state_s = S_LOAD;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    err_set_s    = 1'b1;
                    next_state_s = S_DONE;
                end else begin
                    cnt_load_s   = 1'b1;
                    cnt_ld_val_s = lo_r;
                    next_state_s = S_UP;
                end
            end
            S_UP: begin
                if (abort) begin
                    err_set_s    = 1'b1;
                    next_state_s = S_DONE;
                end else if (c_in != hi_r) begin
                    cnt_en_s  = 1'b1;
                    cnt_dir_s = 1'b1;
                end else begin
`ifdef SWEEP_DWELL_EN
                    // The arrival cycle is the first hold cycle.
                    dwell_ld_s   = 1'b1;
                    next_state_s = S_DW_HI;
`else
                    cnt_en_s     = 1'b1;
                    cnt_dir_s    = 1'b0;
                    next_state_s = S_DOWN;
`endif
                end
            end
            S_DOWN: begin
                if (abort) begin
                    err_set_s    = 1'b1;
                    next_state_s = S_DONE;
                end else if (c_in != lo_r) begin
                    cnt_en_s  = 1'b1;
                    cnt_dir_s = 1'b0;
                end else begin
                    cyc_inc_s = 1'b1;
                    if (cyc_next_s == n_cyc_r) begin
                        next_state_s = S_DONE;
                    end else begin
`ifdef SWEEP_DWELL_EN
                        dwell_ld_s   = 1'b1;
                        next_state_s = S_DW_LO;
`else
                        cnt_en_s     = 1'b1;
                        cnt_dir_s    = 1'b1;
                        next_state_s = S_UP;
`endif
                    end
                end
            end
`ifdef SWEEP_DWELL_EN
            S_DW_HI: begin
                if (abort) begin
                    err_set_s    = 1'b1;
                    next_state_s = S_DONE;
                end else if (dwell_r >= DWELL_C) begin
                    cnt_en_s     = 1'b1;
                    cnt_dir_s    = 1'b0;
                    next_state_s = S_DOWN;
                end else begin
                    dwell_inc_s = 1'b1;
                end
            end
            S_DW_LO: begin
                if (abort) begin
                    err_set_s    = 1'b1;
                    next_state_s = S_DONE;
                end else if (dwell_r >= DWELL_C) begin
                    cnt_en_s     = 1'b1;
                    cnt_dir_s    = 1'b1;
                    next_state_s = S_UP;
                end else begin
                    dwell_inc_s = 1'b1;
                end
            end
`endif
            S_DONE: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State, shadow configuration and status registers.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_r   <= S_IDLE;
            lo_r      <= {W{1'b0}};
            hi_r      <= {W{1'b0}};
            n_cyc_r   <= {CYC_W{1'b0}};
            cyc_cnt_r <= {CYC_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
`ifdef SWEEP_DWELL_EN
            dwell_r   <= 8'd0;
`endif
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != S_IDLE);
            done_r  <= (next_state_s == S_DONE);
            if (latch_s) begin
                lo_r      <= lo_lim;
                hi_r      <= hi_lim;
                n_cyc_r   <= n_cyc;
                cyc_cnt_r <= {CYC_W{1'b0}};
                err_r     <= 1'b0;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
            // Saturate at the programmed count; there is no wrap path.
            if (cyc_inc_s && (cyc_cnt_r != n_cyc_r)) begin
                cyc_cnt_r <= cyc_next_s;
            end
`ifdef SWEEP_DWELL_EN
            if (dwell_ld_s) begin
                dwell_r <= 8'd1;
            end else if (dwell_inc_s) begin
                dwell_r <= dwell_r + 8'd1;
            end
`endif
        end
    end

    assign cnt_load   = cnt_load_s;
    assign cnt_ld_val = cnt_ld_val_s;
    assign cnt_en     = cnt_en_s;
    assign cnt_dir    = cnt_dir_s;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign cyc_cnt    = cyc_cnt_r;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: models the shared counter, runs a vector table of sweeps
// and hand-written reset / abort / handshake / sequence scenarios.
module tb_counter_sweep_ctrl;

    localparam int TB_DWELL = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] lo_lim = 8'd0;
    logic [7:0] hi_lim = 8'd0;
    logic [7:0] n_cyc = 8'd0;
    logic [7:0] c = 8'd0;
    logic       cnt_load;
    logic [7:0] cnt_ld_val;
    logic       cnt_en;
    logic       cnt_dir;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cyc_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int r_lat, r_loads, r_en0_hi, cap_n;
    bit r_oor, r_to;
    int cap [0:63];

    counter_sweep_ctrl #(.W(8), .CYC_W(8), .DWELL(TB_DWELL)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .lo_lim(lo_lim), .hi_lim(hi_lim), .n_cyc(n_cyc), .c_in(c),
        .cnt_load(cnt_load), .cnt_ld_val(cnt_ld_val), .cnt_en(cnt_en), .cnt_dir(cnt_dir),
        .busy(busy), .done(done), .err(err), .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    // Shared up/down counter as the sequencer drives it.
    always @(posedge clk) begin
        if (cnt_load) c <= cnt_ld_val;
        else if (cnt_en) c <= cnt_dir ? c + 8'd1 : c - 8'd1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start a sweep and sample every cycle until done (bounded).
    task automatic run_sweep(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] n);
        bit loaded;
        @(negedge clk);
        lo_lim = lo; hi_lim = hi; n_cyc = n; start = 1'b1;
        r_lat = 0; r_loads = 0; r_en0_hi = 0; cap_n = 0; r_oor = 1'b0; r_to = 1'b1; loaded = 1'b0;
        for (int s = 1; s <= 2000; s++) begin
            @(negedge clk);
            start = 1'b0;
            if (cnt_load) r_loads++;
            if (done) begin
                r_lat = s; r_to = 1'b0;
                break;
            end
            if (loaded) begin
                if (c < lo || c > hi) r_oor = 1'b1;
                if (cap_n < 64) cap[cap_n] = int'(c);
                cap_n++;
                if (c == hi && !cnt_en) r_en0_hi++;
            end
            if (cnt_load) loaded = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] n;
        logic       exp_err;
        logic [7:0] exp_cyc;
        int         lat_base;
        int         turns;
    } vec_t;

    vec_t vecs [0:6];

    initial begin
        int exp_lat;
        int seq_basic [0:12];
        int seq_dwell [0:7];
        int idx;
        bit seen;

        vecs[0] = '{8'd2,   8'd5,   8'd2, 1'b0, 8'd2, 15,  3};
        vecs[1] = '{8'd5,   8'd5,   8'd1, 1'b1, 8'd0, 1,   0};
        vecs[2] = '{8'd7,   8'd3,   8'd2, 1'b1, 8'd0, 1,   0};
        vecs[3] = '{8'd2,   8'd6,   8'd0, 1'b1, 8'd0, 1,   0};
        vecs[4] = '{8'd10,  8'd11,  8'd3, 1'b0, 8'd3, 9,   5};
        vecs[5] = '{8'd0,   8'd255, 8'd1, 1'b0, 8'd1, 513, 1};
        vecs[6] = '{8'd250, 8'd255, 8'd4, 1'b0, 8'd4, 43,  7};
        seq_basic = '{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
        seq_dwell = '{1, 2, 3, 3, 3, 3, 2, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({cnt_load, cnt_en, cnt_dir, busy, done, err}), 0);
        check("reset_cyc_ldval", int'({cyc_cnt, cnt_ld_val}), 0);
        resetn = 1'b0;
        repeat (2) @(negedge clk);

        // Vector table
        for (int v = 0; v < 7; v++) begin
            run_sweep(vecs[v].lo, vecs[v].hi, vecs[v].n);
            exp_lat = vecs[v].lat_base;
`ifdef SWEEP_DWELL_EN
            exp_lat = exp_lat + TB_DWELL * vecs[v].turns;
`endif
            check($sformatf("v%0d_timeout", v), int'(r_to), 0);
            check($sformatf("v%0d_latency", v), r_lat, exp_lat);
            check($sformatf("v%0d_err", v), int'(err), int'(vecs[v].exp_err));
            check($sformatf("v%0d_cyc_cnt", v), int'(cyc_cnt), int'(vecs[v].exp_cyc));
            check($sformatf("v%0d_loads", v), r_loads, vecs[v].exp_err ? 0 : 1);
            check($sformatf("v%0d_busy_at_done", v), int'(busy), 1);
            if (!vecs[v].exp_err) begin
                check($sformatf("v%0d_final_c", v), int'(c), int'(vecs[v].lo));
                check($sformatf("v%0d_in_range", v), int'(r_oor), 0);
            end
            @(negedge clk);
            check($sformatf("v%0d_busy_after", v), int'({busy, done}), 0);
        end

        // Exact counter trajectory
`ifdef SWEEP_DWELL_EN
        run_sweep(8'd1, 8'd3, 8'd1);
        check("dwell_len", cap_n, 8);
        for (int i = 0; i < 8; i++) check($sformatf("dwell_c%0d", i), cap[i], seq_dwell[i]);
        check("dwell_en0_at_hi", r_en0_hi, TB_DWELL);
        check("dwell_final", int'(c), 1);
`else
        run_sweep(8'd2, 8'd5, 8'd2);
        check("basic_len", cap_n, 13);
        for (int i = 0; i < 13; i++) check($sformatf("basic_c%0d", i), cap[i], seq_basic[i]);
        check("basic_final", int'(c), 2);
`endif
        @(negedge clk);

        // Reset mid-sweep while UP at c=4
        lo_lim = 8'd0; hi_lim = 8'd10; n_cyc = 8'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int s = 0; s < 50; s++) begin
            if (c == 8'd4 && cnt_en && cnt_dir) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("rst_reach_c4", int'(seen), 1);
        resetn = 1'b1;
        #1;
        check("rst_mid_outputs", int'({cnt_load, cnt_en, cnt_dir, busy, done, err}), 0);
        check("rst_mid_cyc", int'(cyc_cnt), 0);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        run_sweep(8'd1, 8'd2, 8'd1);
        check("post_rst_timeout", int'(r_to), 0);
        check("post_rst_err", int'(err), 0);
        check("post_rst_final", int'(c), 1);
        @(negedge clk);

        // Abort in UP at 0x40
        lo_lim = 8'd0; hi_lim = 8'd255; n_cyc = 8'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int s = 0; s < 300; s++) begin
            if (c == 8'h40) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("abort_reach_40", int'(seen), 1);
        abort = 1'b1;
        #1;
        check("abort_en_low", int'({cnt_en, cnt_load}), 0);
        @(negedge clk); abort = 1'b0;
        check("abort_done_err", int'({done, err}), 3);
        check("abort_cyc", int'(cyc_cnt), 0);
        check("abort_frozen", int'(c), 8'h40);
        @(negedge clk);
        check("abort_idle", int'(busy), 0);
        check("abort_still_frozen", int'(c), 8'h40);

        // Handshake: held / re-pulsed start and hi_lim change while busy
        lo_lim = 8'd1; hi_lim = 8'd3; n_cyc = 8'd1; start = 1'b1;
        r_loads = 0; r_to = 1'b1; r_lat = 0;
        for (int s = 1; s <= 100; s++) begin
            @(negedge clk);
            if (s == 3) start = 1'b0;
            if (s == 4) start = 1'b1;
            if (s == 5) hi_lim = 8'd200;
            if (s == 6) start = 1'b0;
            if (cnt_load) r_loads++;
            if (c > 8'd3) r_oor = 1'b1;
            if (done) begin r_lat = s; r_to = 1'b0; break; end
        end
        exp_lat = 7;
`ifdef SWEEP_DWELL_EN
        exp_lat = exp_lat + TB_DWELL;
`endif
        check("hs_timeout", int'(r_to), 0);
        check("hs_single_load", r_loads, 1);
        check("hs_latency", r_lat, exp_lat);
        check("hs_err", int'(err), 0);
        // Back-to-back: start raised while DONE, seen by IDLE next cycle
        hi_lim = 8'd3; start = 1'b1;
        @(negedge clk);
        check("b2b_idle", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_load", int'({busy, cnt_load}), 3);
        seen = 1'b0;
        for (int s = 0; s < 100; s++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        check("b2b_done", int'(seen), 1);
        check("b2b_err", int'(err), 0);
        check("b2b_cyc", int'(cyc_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
